// File: rtl/sync_line_counter_if.sv
// Control and status bundle for the sync line counter.
// The sequencer/timer chain drives the master side; the counter is the slave.
interface sync_line_counter_if #(
    parameter int W = 9
);
    logic         ce;
    logic         clr;
    logic         ldl;
    logic [W-1:0] d;
    logic [W-1:0] limit;
    logic [W-1:0] cmp;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         running;
    logic         tc;
    logic         match;

    modport master (
        output ce, clr, ldl, d, limit, cmp,
        input  q, qb, running, tc, match
    );

    modport slave (
        input  ce, clr, ldl, d, limit, cmp,
        output q, qb, running, tc, match
    );
endinterface

// File: rtl/sync_line_counter.sv
// Parameterised loadable up-counter with terminal-count and compare strobes.
// Feeds the sync/blank generators with limit-wrap (tc) and compare (match) pulses.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_RUNNING | counts on ce; wraps to 0 at limit (ONESHOT=0)
//   ST_STOPPED | parked at limit after a one-shot run; only clr/load leave it
module sync_line_counter #(
    parameter int W       = 9,
    parameter int ONESHOT = 0
) (
    input  logic                 MasterClock,
    input  logic                 reset,
    sync_line_counter_if.slave   bus
);

    typedef enum logic {
        ST_RUNNING = 1'b0,
        ST_STOPPED = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_q;
    logic [W-1:0] r_qb;
    logic         r_tc;
    logic         r_match;

    logic [W-1:0] w_q_nxt;
    logic [W-1:0] w_q_inc;
    logic         w_tc_nxt;
    logic         w_match_nxt;
    logic         w_at_limit;

    assign w_q_inc    = r_q + W'(1);
    assign w_at_limit = (r_q == bus.limit);

    // Next-state and strobe decode; priority is clr, then load, then count, then hold.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_tc_nxt    = 1'b0;
        w_match_nxt = 1'b0;

        if (bus.clr) begin
            w_q_nxt     = '0;
            w_state_nxt = ST_RUNNING;
        end else if (!bus.ldl) begin
            w_q_nxt     = bus.d;
            w_state_nxt = ST_RUNNING;
            w_match_nxt = (bus.d == bus.cmp);
        end else if (bus.ce && (r_state == ST_RUNNING)) begin
            if (!w_at_limit) begin
                // A count that passes 2^W-1 without hitting limit wraps silently.
                w_q_nxt     = w_q_inc;
                w_match_nxt = (w_q_inc == bus.cmp);
            end else if (ONESHOT != 0) begin
                w_state_nxt = ST_STOPPED;
                w_tc_nxt    = 1'b1;
            end else begin
                w_q_nxt     = '0;
                w_tc_nxt    = 1'b1;
                w_match_nxt = (bus.cmp == '0);
            end
        end
    end

    // State, count and strobe registers; qb is kept as its own register so it never glitches off q.
    always_ff @(posedge MasterClock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUNNING;
            r_q     <= '0;
            r_qb    <= '1;
            r_tc    <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_qb    <= ~w_q_nxt;
            r_tc    <= w_tc_nxt;
            r_match <= w_match_nxt;
        end
    end

    assign bus.q       = r_q;
    assign bus.qb      = r_qb;
    assign bus.running = (r_state == ST_RUNNING);
    assign bus.tc      = r_tc;
    assign bus.match   = r_match;

endmodule

// File: tb/tb_sync_line_counter.sv
// Bench for sync_line_counter: three instances (W=9 free-run, W=9 one-shot,
// W=4 free-run) checked every cycle against an arithmetic reference model.
module tb_sync_line_counter;

    logic MasterClock = 1'b0;
    logic reset;

    always #5 MasterClock = ~MasterClock;

    sync_line_counter_if #(.W(9)) b0 ();
    sync_line_counter_if #(.W(9)) b1 ();
    sync_line_counter_if #(.W(4)) b2 ();

    sync_line_counter #(.W(9), .ONESHOT(0)) u0 (.MasterClock(MasterClock), .reset(reset), .bus(b0));
    sync_line_counter #(.W(9), .ONESHOT(1)) u1 (.MasterClock(MasterClock), .reset(reset), .bus(b1));
    sync_line_counter #(.W(4), .ONESHOT(0)) u2 (.MasterClock(MasterClock), .reset(reset), .bus(b2));

    // stimulus per unit
    logic        s_ce  [3];
    logic        s_clr [3];
    logic        s_ldl [3];
    logic [15:0] s_d   [3];
    logic [15:0] s_lim [3];
    logic [15:0] s_cmp [3];

    assign b0.ce = s_ce[0];  assign b0.clr = s_clr[0];  assign b0.ldl = s_ldl[0];
    assign b1.ce = s_ce[1];  assign b1.clr = s_clr[1];  assign b1.ldl = s_ldl[1];
    assign b2.ce = s_ce[2];  assign b2.clr = s_clr[2];  assign b2.ldl = s_ldl[2];
    assign b0.d = s_d[0][8:0];  assign b0.limit = s_lim[0][8:0];  assign b0.cmp = s_cmp[0][8:0];
    assign b1.d = s_d[1][8:0];  assign b1.limit = s_lim[1][8:0];  assign b1.cmp = s_cmp[1][8:0];
    assign b2.d = s_d[2][3:0];  assign b2.limit = s_lim[2][3:0];  assign b2.cmp = s_cmp[2][3:0];

    // observed outputs, zero-extended
    logic [15:0] o_q  [3];
    logic [15:0] o_qb [3];
    logic        o_run[3];
    logic        o_tc [3];
    logic        o_mt [3];

    assign o_q[0] = 16'(b0.q);  assign o_qb[0] = 16'(b0.qb);
    assign o_q[1] = 16'(b1.q);  assign o_qb[1] = 16'(b1.qb);
    assign o_q[2] = 16'(b2.q);  assign o_qb[2] = 16'(b2.qb);
    assign o_run[0] = b0.running;  assign o_tc[0] = b0.tc;  assign o_mt[0] = b0.match;
    assign o_run[1] = b1.running;  assign o_tc[1] = b1.tc;  assign o_mt[1] = b1.match;
    assign o_run[2] = b2.running;  assign o_tc[2] = b2.tc;  assign o_mt[2] = b2.match;

    // reference model state
    int wid  [3] = '{9, 9, 4};
    bit m_os [3] = '{1'b0, 1'b1, 1'b0};
    int m_q  [3];
    bit m_stop[3];
    bit m_tc [3];
    bit m_mt [3];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s unit%0d observed=%0h expected=%0h t=%0t", tag, k, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int mod;
            mod = 1 << wid[k];
            chk("q",       k, o_q[k],           16'(m_q[k]));
            chk("qb",      k, o_qb[k],          16'((mod - 1) - m_q[k]));
            chk("running", k, 16'(o_run[k]),    16'(!m_stop[k]));
            chk("tc",      k, 16'(o_tc[k]),     16'(m_tc[k]));
            chk("match",   k, 16'(o_mt[k]),     16'(m_mt[k]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_q[k] = 0; m_stop[k] = 1'b0; m_tc[k] = 1'b0; m_mt[k] = 1'b0;
        end
    endtask

    // next-cycle prediction from the behavioural rules
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int mod, d, lim, cmp;
            mod = 1 << wid[k];
            d   = int'(s_d[k]);
            lim = int'(s_lim[k]);
            cmp = int'(s_cmp[k]);
            if (s_clr[k]) begin
                m_q[k] = 0; m_stop[k] = 1'b0; m_tc[k] = 1'b0; m_mt[k] = 1'b0;
            end else if (!s_ldl[k]) begin
                m_q[k] = d; m_stop[k] = 1'b0; m_tc[k] = 1'b0; m_mt[k] = (d == cmp);
            end else if (s_ce[k] && !m_stop[k]) begin
                if (m_q[k] != lim) begin
                    m_q[k]  = (m_q[k] + 1) % mod;
                    m_tc[k] = 1'b0;
                    m_mt[k] = (m_q[k] == cmp);
                end else if (m_os[k]) begin
                    m_stop[k] = 1'b1; m_tc[k] = 1'b1; m_mt[k] = 1'b0;
                end else begin
                    m_q[k] = 0; m_tc[k] = 1'b1; m_mt[k] = (cmp == 0);
                end
            end else begin
                m_tc[k] = 1'b0; m_mt[k] = 1'b0;
            end
        end
    endtask

    task automatic set(input int k, input bit ce, input bit clr, input bit ldl,
                       input int d, input int lim, input int cmp);
        int mask;
        mask       = (1 << wid[k]) - 1;
        s_ce[k]    = ce;
        s_clr[k]   = clr;
        s_ldl[k]   = ldl;
        s_d[k]     = 16'(d & mask);
        s_lim[k]   = 16'(lim & mask);
        s_cmp[k]   = 16'(cmp & mask);
    endtask

    task automatic idle(input int k);
        set(k, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge MasterClock);
        #1;
        check_all();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) idle(k);
        reset = 1'b1;
        model_reset();
        #3;
        check_all();
        @(negedge MasterClock);
        reset = 1'b0;

        // free-run: limit=5 cmp=3, q 1,2,3,4,5,0,1
        set(0, 1, 0, 1, 0, 5, 3);
        repeat (7) tick();

        // ce gating from q=0
        set(0, 0, 1, 1, 0, 5, 3); tick();
        set(0, 1, 0, 1, 0, 5, 3); tick();
        set(0, 0, 0, 1, 0, 5, 3); tick();
        set(0, 1, 0, 1, 0, 5, 3); tick();
        set(0, 0, 0, 1, 0, 5, 3); tick();

        // load near top, wrap via limit=0x1F2
        set(0, 0, 0, 0, 'h1F0, 'h1F2, 3); tick();
        set(0, 1, 0, 1, 0, 'h1F2, 3);
        repeat (3) tick();
        // clr beats load
        set(0, 1, 1, 0, 'h55, 'h1F2, 'h55); tick();
        idle(0);

        // one-shot: stop at 3, ignore ce, restart by load of 1
        set(1, 1, 0, 1, 0, 3, 2);
        repeat (6) tick();
        set(1, 1, 0, 0, 1, 3, 2); tick();
        set(1, 1, 0, 1, 0, 3, 2);
        repeat (3) tick();
        idle(1);

        // W=4: load 10 above limit 4, natural wrap then limit wrap
        set(2, 0, 0, 0, 10, 4, 7); tick();
        set(2, 1, 0, 1, 0, 4, 7);
        repeat (12) tick();
        idle(2);

        // limit=0: q stays 0, tc and match (cmp=0) every ce cycle
        set(0, 0, 1, 1, 0, 0, 0); tick();
        set(0, 1, 0, 1, 0, 0, 0);
        repeat (3) tick();

        // limit=all ones: wrap through the limit rule
        set(0, 0, 0, 0, 510, 511, 0); tick();
        set(0, 1, 0, 1, 0, 511, 0);
        repeat (3) tick();

        // randomized phase, live limit/cmp changes included
        repeat (400) begin
            for (int k = 0; k < 3; k++) begin
                int mask;
                mask = (1 << wid[k]) - 1;
                set(k,
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 15) != 0),
                    int'($urandom_range(0, mask)),
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, mask)),
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, mask)));
            end
            tick();
        end

        // async reset mid-count at q=7
        for (int k = 0; k < 3; k++) idle(k);
        set(0, 0, 1, 1, 0, 100, 50); tick();
        set(0, 1, 0, 1, 0, 100, 50);
        repeat (7) tick();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
